// File: rtl/firefly_pkg.sv
// Shared types and default constants for the firefly swarm flash sequencer.
package firefly_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLASH = 2'd2
    } chan_state_t;

    localparam int DEF_CH         = 4;
    localparam int DEF_PULSE_W    = 15000;
    localparam int DEF_DELAY_STEP = 2500;
    localparam int DEF_CW         = 16;

endpackage

// File: rtl/firefly_chan.sv
// One signal-firefly channel: IDLE -> WAIT (DELAY cycles) -> FLASH (PULSE_W cycles) -> IDLE.
module firefly_chan
    import firefly_pkg::*;
#(
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int DELAY   = 0,
    parameter int CW      = DEF_CW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic flash,
    output logic free,
    output logic active_next
);

    localparam logic [CW-1:0] WAIT_LAST  = CW'((DELAY > 0) ? DELAY - 1 : 0);
    localparam logic [CW-1:0] FLASH_LAST = CW'(PULSE_W - 1);

    chan_state_t     state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            WAIT: begin
                if (cnt_reg == WAIT_LAST) begin
                    state_next = FLASH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            FLASH: begin
                if (cnt_reg == FLASH_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: ;
        endcase
        // A start always overrides the natural progression, including the final FLASH cycle.
        if (start) begin
            state_next = (DELAY == 0) ? FLASH : WAIT;
            cnt_next   = '0;
        end
    end

    assign flash       = (state_reg == FLASH);
    assign free        = (state_reg == IDLE) || ((state_reg == FLASH) && (cnt_reg == FLASH_LAST));
    assign active_next = (state_next != IDLE);

endmodule

// File: rtl/firefly_swarm.sv
// Queen-triggered staggered flash sequencer; FIREFLY_RETRIG_EN lets a new trigger restart busy channels.
module firefly_swarm
    import firefly_pkg::*;
#(
    parameter int CH         = DEF_CH,
    parameter int PULSE_W    = DEF_PULSE_W,
    parameter int DELAY_STEP = DEF_DELAY_STEP,
    parameter int CW         = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f0,
    output logic [CH-1:0] f1,
    output logic          busy,
    output logic [7:0]    flash_cnt
);

    logic          sync1_reg, sync2_reg, prev_reg;
    logic          trigger;
    logic [CH-1:0] start;
    logic [CH-1:0] free;
    logic [CH-1:0] active_next;
    logic          busy_reg;
    logic [7:0]    flash_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= f0;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign trigger = sync2_reg & ~prev_reg;

    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
`ifdef FIREFLY_RETRIG_EN
        assign start[gi] = trigger;
`else
        // Channel 0 gates acceptance for the whole swarm.
        assign start[gi] = trigger & free[0] & free[gi];
`endif
        firefly_chan #(
            .PULSE_W (PULSE_W),
            .DELAY   (gi * DELAY_STEP),
            .CW      (CW)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (start[gi]),
            .flash       (f1[gi]),
            .free        (free[gi]),
            .active_next (active_next[gi])
        );
    end

    // Registered from next-state so busy lines up with the channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg      <= 1'b0;
            flash_cnt_reg <= 8'd0;
        end else begin
            busy_reg <= |active_next;
            if (start[0]) begin
                flash_cnt_reg <= flash_cnt_reg + 8'd1;
            end
        end
    end

    assign busy      = busy_reg;
    assign flash_cnt = flash_cnt_reg;

endmodule

// File: tb/tb_firefly_swarm.sv
// Scoreboard bench for firefly_swarm (CH=4, PULSE_W=8, DELAY_STEP=5); honours FIREFLY_RETRIG_EN.
module tb_firefly_swarm;

    localparam int CH = 4;
    localparam int PW = 8;
    localparam int DS = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          f0 = 1'b0;
    logic [CH-1:0] f1;
    logic          busy;
    logic [7:0]    flash_cnt;

    always #5 clk = ~clk;

    firefly_swarm #(
        .CH         (CH),
        .PULSE_W    (PW),
        .DELAY_STEP (DS),
        .CW         (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f0        (f0),
        .f1        (f1),
        .busy      (busy),
        .flash_cnt (flash_cnt)
    );

    typedef struct packed {
        logic [CH-1:0] f1;
        logic          busy;
        logic [7:0]    cnt;
    } exp_t;

    exp_t exp_q[$];
    logic pat_q[$];
    int   trig_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected outputs at cycle c from the accepted trigger edges (index of E0 per trigger).
    function automatic exp_t model(input int c);
        exp_t e;
        int   latest;
        int   n;
        int   st;
        e = '0;
        latest = -1;
        n = 0;
        foreach (trig_q[j]) begin
            if (trig_q[j] + 2 <= c) begin
                n++;
                latest = trig_q[j];
            end
        end
        e.cnt = 8'(n);
        if (latest >= 0) begin
            for (int k = 0; k < CH; k++) begin
                st = latest + 2 + k * DS;
                if (c >= st && c < st + PW) e.f1[k] = 1'b1;
                if (c >= latest + 2 && c < st + PW) e.busy = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic build(input int n);
        exp_q.delete();
        for (int c = 0; c < n; c++) exp_q.push_back(model(c));
    endtask

    task automatic set_pat(input int n, input logic v);
        pat_q.delete();
        for (int i = 0; i < n; i++) pat_q.push_back(v);
    endtask

    task automatic run(input string tag);
        exp_t e;
        int   errs0;
        int   ncyc;
        errs0 = failures;
        ncyc = exp_q.size();
        while (exp_q.size() > 0) begin
            f0 = (pat_q.size() > 0) ? pat_q.pop_front() : 1'b0;
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check({tag, ".f1"}, 16'(f1), 16'(e.f1));
            check({tag, ".busy"}, 16'(busy), 16'(e.busy));
            check({tag, ".flash_cnt"}, 16'(flash_cnt), 16'(e.cnt));
        end
        $display("scenario %s: %0d cycles, %0d new errors", tag, ncyc, failures - errs0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".f1"}, 16'(f1), 16'd0);
        check({tag, ".busy"}, 16'(busy), 16'd0);
        check({tag, ".flash_cnt"}, 16'(flash_cnt), 16'd0);
    endtask

    initial begin
        // Reset state
        f0 = 1'b0;
        do_reset();
        check_idle("reset");

        // Single one-cycle pulse
        set_pat(30, 1'b0);
        pat_q[0] = 1'b1;
        trig_q = '{0};
        build(30);
        run("single");

        // f0 held high for 100 cycles gives one trigger only
        f0 = 1'b0;
        do_reset();
        set_pat(110, 1'b0);
        for (int i = 0; i < 100; i++) pat_q[i] = 1'b1;
        trig_q = '{0};
        build(110);
        run("held");

        // Second edge 4 cycles after the first
        f0 = 1'b0;
        do_reset();
        set_pat(35, 1'b0);
        pat_q[0] = 1'b1;
        pat_q[4] = 1'b1;
`ifdef FIREFLY_RETRIG_EN
        trig_q = '{0, 4};
`else
        trig_q = '{0};
`endif
        build(35);
        run("retrig");

        // Reset during the sequence aborts everything at once
        f0 = 1'b0;
        do_reset();
        set_pat(11, 1'b0);
        pat_q[0] = 1'b1;
        trig_q = '{0};
        build(11);
        run("pre_abort");
        #3;
        rst_n = 1'b0;
        #1;
        check_idle("async_abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle("post_abort");
        set_pat(30, 1'b0);
        trig_q.delete();
        build(30);
        run("quiet");

        // f0 already high when reset releases
        f0 = 1'b1;
        do_reset();
        set_pat(30, 1'b1);
        trig_q = '{0};
        build(30);
        run("high_at_release");

        // 256 spaced triggers wrap flash_cnt back to 0
        f0 = 1'b0;
        do_reset();
        set_pat(256 * 30 + 5, 1'b0);
        trig_q.delete();
        for (int j = 0; j < 256; j++) begin
            pat_q[j * 30] = 1'b1;
            trig_q.push_back(j * 30);
        end
        build(256 * 30 + 5);
        run("wrap");
        check("wrap_final", 16'(flash_cnt), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
